number_display_scheduler: RTL and testbench
===========================================

// Module: number_display_scheduler
// PURPOSE
//  Time-shares one number_display among NUM_SOURCES binary values: round-robin source
//  selection, serial shift-add-3 binary-to-decimal conversion, leading-zero blanking.
//  Output is a registered digit_t vector that feeds the digit-pattern/display stage.
//  Replaces the combinational %10 / /10 chain with a NUMBER_WIDTH-cycle sequencer.
// PARAMETERS
//  NUMBER_WIDTH  8  bit width of each source value
//  NUM_SOURCES   2  number of requesters sharing the display (>=1)
//  DWELL_CYCLES  4  cycles each converted value stays published before advancing (>=1)
//  DIGITS_COUNT  derived: $rtoi($ceil(NUMBER_WIDTH*$log10(2))), not overridable
// PORTS
//  clk         in   1                          clock
//  rst         in   1                          synchronous reset, active-high
//  numbers     in   NUM_SOURCES*NUMBER_WIDTH   source k at numbers[NUMBER_WIDTH*k+:NUMBER_WIDTH]
//  hold        in   1                          1 = stay on current source (refresh it)
//  digits      out  4*DIGITS_COUNT             digit_t per position; digits[4*i+:4], i=0 most significant
//  source_idx  out  $clog2(NUM_SOURCES)+1      source shown on digits
//  valid       out  1                          digits hold a completed conversion
//  busy        out  1                          1 while not in DWELL
// BEHAVIOUR
//  - Reset (rst=1 at edge): state=LOAD, current source=0, digits=all empty_digit (10),
//    source_idx=0, valid=0, BCD shift register and counters cleared. rst wins over all.
//  - FSM: LOAD -> CONVERT -> PUBLISH -> DWELL -> LOAD.
//    LOAD (1 cycle): capture numbers[source]; clear BCD register (4*DIGITS_COUNT bits).
//    CONVERT (NUMBER_WIDTH cycles): each cycle, every BCD nibble >=5 gets +3, then
//      {bcd,bin} shifts left by 1 (bin MSB enters bcd LSB). Nibble adds are 4-bit, no carry
//      between nibbles before the shift.
//    PUBLISH (1 cycle): digits <= BCD nibbles with leading zeros -> empty_digit; least
//      significant digit is never blanked (value 0 shows "0"); interior zeros kept.
//      source_idx <= current source; valid <= 1.
//    DWELL (DWELL_CYCLES cycles): outputs stable. On last cycle: if hold=1 source unchanged,
//      else source <= (source==NUM_SOURCES-1) ? 0 : source+1.
//  - Latency: digits update at the edge ending PUBLISH, NUMBER_WIDTH+2 cycles after LOAD
//    entry; rotation period per source = NUMBER_WIDTH+2+DWELL_CYCLES cycles.
//  - numbers sampled only in LOAD; changes during CONVERT/PUBLISH/DWELL seen next visit.
//  - hold sampled only on the last DWELL cycle; hold pulses elsewhere have no effect.
//  - NUM_SOURCES=1: source always 0, value re-converted every period.
//  - digits/source_idx change only in PUBLISH or reset; never a partial conversion visible.
//  - Reset mid-CONVERT aborts conversion: nothing published, digits go blank, valid=0.
//  - busy=0 only in DWELL; reset value busy=1.
//  - Digit codes >9 other than empty_digit never produced.
// TESTING (NUMBER_WIDTH=8, NUM_SOURCES=2, DWELL_CYCLES=4 unless noted)
//  - Reset, src0=255, src1=7 -> after 10 cycles digits={2,5,5}, idx=0, valid=1; 4 cycles
//    later rotate, 10 more -> digits={E,E,7}, idx=1 (E=empty_digit); then back to idx 0.
//  - src0=0 -> {E,E,0}; src0=100 -> {1,0,0}; src0=10 -> {E,1,0}; exhaustive 0..255
//    vs reference model (value%10 chain with blanking).
//  - hold=1 on last DWELL cycle with idx=0 -> next publish idx=0; hold only mid-CONVERT -> rotates.
//  - Change src0 255->3 during CONVERT -> publish 255; next visit publishes {E,E,3}.
//  - Assert rst 5 cycles into CONVERT -> digits all E, valid=0, idx=0; resume normal sequence.
//  - NUM_SOURCES=1, NUMBER_WIDTH=16, src=65535 -> digits={6,5,5,3,5}, period 22 cycles.

Source files
------------

// File: rtl/number_display_scheduler.sv
// number_display_scheduler: shares one numeric display among several binary
// sources. Sources are visited round-robin; each value is converted to decimal
// serially (shift-add-3, one bit per cycle), leading zeros are blanked, and the
// result is published as a registered digit vector for a fixed dwell time.
//
// Handshake/timing contract: there is no request/acknowledge. 'numbers' is
// sampled only in LOAD and 'hold' only on the last DWELL cycle. 'digits',
// 'source_idx' and 'valid' change only at the edge ending PUBLISH (or on reset),
// so a consumer may sample them on any cycle and never sees a partial
// conversion. 'busy' is low exactly while a published value is dwelling.
module number_display_scheduler #(
  parameter int NUMBER_WIDTH = 8,
  parameter int NUM_SOURCES  = 2,
  parameter int DWELL_CYCLES = 4,
  localparam int DIGITS_COUNT = $rtoi($ceil(NUMBER_WIDTH * $log10(2.0))),
  localparam int SW = $clog2(NUM_SOURCES) + 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_SOURCES*NUMBER_WIDTH-1:0] numbers,
  input  logic                                hold,
  output logic [4*DIGITS_COUNT-1:0]           digits,
  output logic [SW-1:0]                       source_idx,
  output logic                                valid,
  output logic                                busy,
  output logic [1:0]                          dbg_state
);

  typedef enum logic [1:0] {LOAD, CONVERT, PUBLISH, DWELL} state_t;
  typedef logic [3:0] digit_t;

  localparam digit_t EMPTY_DIGIT = 4'd10;
  localparam int     BW          = 4 * DIGITS_COUNT;
  localparam int     CW          = $clog2(NUMBER_WIDTH + DWELL_CYCLES) + 1;

  state_t                  state;
  logic [SW-1:0]           src;
  logic [NUMBER_WIDTH-1:0] bin;
  logic [BW-1:0]           bcd;
  logic [CW-1:0]           cnt;
  logic [NUMBER_WIDTH-1:0] sel_num;
  logic [BW-1:0]           bcd_adj;
  logic [BW-1:0]           bcd_blank;
  logic                    leading;

  assign dbg_state = state;

  // Pick the value of the source currently being served.
  always_comb begin
    sel_num = '0;
    for (int k = 0; k < NUM_SOURCES; k++) begin
      if (src == SW'(k)) sel_num = numbers[NUMBER_WIDTH*k +: NUMBER_WIDTH];
    end
  end

  // Add-3 correction: each nibble >= 5 gets +3 (4-bit, no inter-nibble carry).
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < DIGITS_COUNT; i++) begin
      bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end
  end

  // Reorder to most-significant-first and blank leading zeros; the ones digit
  // is always shown so a zero value displays "0".
  always_comb begin
    bcd_blank = '0;
    leading   = 1'b1;
    for (int i = 0; i < DIGITS_COUNT; i++) begin
      if (leading && (bcd[4*(DIGITS_COUNT-1-i) +: 4] == 4'd0) && (i != DIGITS_COUNT-1)) begin
        bcd_blank[4*i +: 4] = EMPTY_DIGIT;
      end else begin
        leading             = 1'b0;
        bcd_blank[4*i +: 4] = bcd[4*(DIGITS_COUNT-1-i) +: 4];
      end
    end
  end

  // Sequencer: LOAD -> CONVERT -> PUBLISH -> DWELL -> LOAD, all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD;
      src        <= '0;
      bin        <= '0;
      bcd        <= '0;
      cnt        <= '0;
      digits     <= {DIGITS_COUNT{EMPTY_DIGIT}};
      source_idx <= '0;
      valid      <= 1'b0;
      busy       <= 1'b1;
    end else begin
      case (state)
        LOAD: begin
          bin   <= sel_num;
          bcd   <= '0;
          cnt   <= '0;
          state <= CONVERT;
        end
        CONVERT: begin
          bcd <= {bcd_adj[BW-2:0], bin[NUMBER_WIDTH-1]};
          bin <= bin << 1;
          if (cnt == CW'(NUMBER_WIDTH - 1)) begin
            cnt   <= '0;
            state <= PUBLISH;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PUBLISH: begin
          digits     <= bcd_blank;
          source_idx <= src;
          valid      <= 1'b1;
          busy       <= 1'b0;
          cnt        <= '0;
          state      <= DWELL;
        end
        DWELL: begin
          if (cnt == CW'(DWELL_CYCLES - 1)) begin
            cnt   <= '0;
            busy  <= 1'b1;
            state <= LOAD;
            if (!hold) src <= (src == SW'(NUM_SOURCES - 1)) ? '0 : src + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_number_display_scheduler.sv
// Bench for number_display_scheduler: two instances (8-bit/2 sources and
// 16-bit/1 source) share clock and reset and are checked every cycle against a
// period/phase reference model with a %10-based decimal reference.
module tb_number_display_scheduler;

  localparam int W  = 8;
  localparam int N  = 2;
  localparam int D  = 4;
  localparam int P  = W + 2 + D;
  localparam int W1 = 16;
  localparam int P1 = W1 + 2 + D;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] numbers;
  logic        hold;
  logic [11:0] digits;
  logic [1:0]  source_idx;
  logic        valid;
  logic        busy;
  logic [1:0]  dbg_state;

  logic [15:0] numbers1;
  logic [19:0] digits1;
  logic [0:0]  source_idx1;
  logic        valid1;
  logic        busy1;
  logic [1:0]  dbg_state1;

  int n_cmp = 0;
  int n_err = 0;

  // model state
  int          t;
  int          m_src, m_val, m_idx;
  logic [31:0] m_dig;
  bit          m_valid, m_busy;
  int          m1_val;
  logic [31:0] m1_dig;
  bit          m1_valid, m1_busy;

  number_display_scheduler #(.NUMBER_WIDTH(W), .NUM_SOURCES(N), .DWELL_CYCLES(D)) u_dut (
    .clk(clk), .rst(rst), .numbers(numbers), .hold(hold), .digits(digits),
    .source_idx(source_idx), .valid(valid), .busy(busy), .dbg_state(dbg_state)
  );

  number_display_scheduler #(.NUMBER_WIDTH(W1), .NUM_SOURCES(1), .DWELL_CYCLES(D)) u_dut1 (
    .clk(clk), .rst(rst), .numbers(numbers1), .hold(hold), .digits(digits1),
    .source_idx(source_idx1), .valid(valid1), .busy(busy1), .dbg_state(dbg_state1)
  );

  // clock
  always #5 clk = ~clk;

  // decimal reference: digit i=0 is most significant, leading zeros -> 10
  function automatic logic [31:0] dref(input int unsigned v, input int nd);
    logic [31:0] r;
    int unsigned x;
    int          dg [8];
    bit          blank;
    r = '0;
    x = v;
    for (int i = nd - 1; i >= 0; i--) begin
      dg[i] = int'(x % 10);
      x     = x / 10;
    end
    blank = 1'b1;
    for (int i = 0; i < nd; i++) begin
      if (blank && dg[i] == 0 && i != nd - 1) r[4*i +: 4] = 4'd10;
      else begin
        blank       = 1'b0;
        r[4*i +: 4] = 4'(dg[i]);
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] all_blank(input int nd);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < nd; i++) r[4*i +: 4] = 4'd10;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d: got %0h expected %0h", tag, t, obs, exp);
    end
  endtask

  // one clock: advance the model at the edge, compare on the falling edge
  task automatic tick();
    int ph, ph1;
    @(posedge clk);
    if (rst) begin
      t = 0; m_src = 0; m_idx = 0; m_valid = 0; m_busy = 1;
      m_dig = all_blank(3);
      m1_valid = 0; m1_busy = 1;
      m1_dig = all_blank(5);
    end else begin
      t++;
      ph  = (t - 1) % P;
      ph1 = (t - 1) % P1;
      if (ph == 0) m_val = int'(numbers[8*m_src +: 8]);
      if (ph == W + 1) begin
        m_dig = dref(m_val, 3); m_idx = m_src; m_valid = 1;
      end
      if (ph == P - 1 && !hold) m_src = (m_src + 1) % N;
      m_busy = !(ph >= W + 1 && ph <= W + D);
      if (ph1 == 0) m1_val = int'(numbers1);
      if (ph1 == W1 + 1) begin
        m1_dig = dref(m1_val, 5); m1_valid = 1;
      end
      m1_busy = !(ph1 >= W1 + 1 && ph1 <= W1 + D);
    end
    @(negedge clk);
    check("digits", 32'(digits), m_dig);
    check("source_idx", 32'(source_idx), 32'(m_idx));
    check("valid", 32'(valid), 32'(m_valid));
    check("busy", 32'(busy), 32'(m_busy));
    check("digits16", 32'(digits1), m1_dig);
    check("source_idx16", 32'(source_idx1), 32'd0);
    check("valid16", 32'(valid1), 32'(m1_valid));
    check("busy16", 32'(busy1), 32'(m1_busy));
  endtask

  initial begin
    t = 0;
    // reset with spec values, then change src0 during CONVERT
    rst = 1'b1; hold = 1'b0;
    numbers = {8'd7, 8'd255};
    numbers1 = 16'hFFFF;
    tick(); tick();
    rst = 1'b0;
    tick();
    numbers = {8'd7, 8'd3};
    repeat (3 * P) tick();

    // directed values 0, 100, 10 on both sources
    numbers = {8'd0, 8'd100};
    repeat (2 * P) tick();
    numbers = {8'd10, 8'd10};
    repeat (2 * P) tick();

    // hold exactly on the last DWELL cycle while showing source 0
    for (int c = 0; c < 4 * P; c++) begin
      hold = ((t % P) == P - 1) && (m_src == 0) && (c < 2 * P);
      tick();
    end
    // hold pulses only mid-CONVERT: must not stop rotation
    for (int c = 0; c < 3 * P; c++) begin
      hold = ((t % P) == 3);
      tick();
    end
    hold = 1'b0;

    // reset 5 cycles into CONVERT
    for (int c = 0; c < P && ((t - 1) % P) != 5; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (2 * P) tick();

    // exhaustive 0..255, one value per period, realigned by reset
    rst = 1'b1; tick(); rst = 1'b0;
    for (int v = 0; v < 256; v++) begin
      numbers  = {8'(v), 8'(v)};
      numbers1 = 16'($urandom);
      hold     = 1'($urandom_range(0, 1));
      repeat (P) tick();
    end

    // random inputs every cycle, occasional hold and reset
    for (int c = 0; c < 1500; c++) begin
      numbers  = 16'($urandom);
      numbers1 = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      hold     = ($urandom_range(0, 2) == 0);
      rst      = ($urandom_range(0, 149) == 0);
      tick();
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
